// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer:
// states, cause codes and mux select codes.
package exc_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LATCH    = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_LOAD_PC  = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_INV  = 2'b01;
   localparam logic [1:0] CAUSE_OVF  = 2'b10;
   localparam logic [1:0] CAUSE_DIV  = 2'b11;

   localparam logic [2:0] SEL_253 = 3'b000;
   localparam logic [2:0] SEL_254 = 3'b001;
   localparam logic [2:0] SEL_255 = 3'b010;

   localparam logic [2:0] PC_SEL_NEXT = 3'b000;
   localparam logic [2:0] PC_SEL_MEM  = 3'b011;

endpackage

// File: rtl/exception_seq_wait_counter.sv
// Loadable down-counter used to time out the
// memory read latency of the vector fetch.
module wait_counter
   import exc_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero,
   output logic         one
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);
   assign one  = (count == W'(1));

endmodule

// File: rtl/exception_seq.sv
// Exception sequencer: saves EPC, fetches the vector
// byte and reloads PC while the control unit stalls.
module exception_seq
   import exc_pkg::*;
#(
   parameter int          MEM_LATENCY = 2,
   parameter logic [2:0]  PC_MEM_SEL  = 3'b011
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       invalid_op,
   input  logic       overflow,
   input  logic       div_zero,
   input  logic       lost_clr,
   output logic       busy,
   output logic       done,
   output logic [2:0] exc_sel,
   output logic       mem_addr_sel,
   output logic       mem_read,
   output logic       epc_write,
   output logic       pc_write,
   output logic [2:0] pc_src_sel,
   output logic [1:0] cause,
   output logic       lost
);

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       sel_q;
   logic [1:0]       cause_q;
   logic             lost_q;
   logic             any_exc;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic             cnt_one;
   logic [CNT_W-1:0] cnt_val;

   assign any_exc = invalid_op | overflow | div_zero;

   wait_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (CNT_W'(MEM_LATENCY)),
      .count    (cnt_val),
      .zero     (cnt_zero),
      .one      (cnt_one)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_exc) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            cnt_load = 1'b1;
            state_d  = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            // zero guard keeps a bad latency from hanging here
            if (cnt_one || cnt_zero) state_d = ST_LOAD_PC;
            else cnt_dec = 1'b1;
         end
         ST_LOAD_PC: state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cause_q <= CAUSE_NONE;
         sel_q   <= SEL_253;
      end else if ((state_q == ST_IDLE) && any_exc) begin
         priority case (1'b1)
            invalid_op: begin
               cause_q <= CAUSE_INV;
               sel_q   <= SEL_253;
            end
            overflow: begin
               cause_q <= CAUSE_OVF;
               sel_q   <= SEL_254;
            end
            default: begin
               cause_q <= CAUSE_DIV;
               sel_q   <= SEL_255;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lost_q <= 1'b0;
      end else if (any_exc && (state_q != ST_IDLE)) begin
         lost_q <= 1'b1;
      end else if (lost_clr) begin
         lost_q <= 1'b0;
      end
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      exc_sel      = SEL_253;
      mem_addr_sel = 1'b0;
      mem_read     = 1'b0;
      epc_write    = 1'b0;
      pc_write     = 1'b0;
      pc_src_sel   = PC_SEL_NEXT;
      unique case (state_q)
         ST_LATCH: begin
            busy         = 1'b1;
            epc_write    = 1'b1;
            mem_addr_sel = 1'b1;
            exc_sel      = sel_q;
         end
         ST_MEM_WAIT: begin
            busy         = 1'b1;
            mem_read     = 1'b1;
            mem_addr_sel = 1'b1;
            exc_sel      = sel_q;
         end
         ST_LOAD_PC: begin
            busy         = 1'b1;
            pc_write     = 1'b1;
            pc_src_sel   = PC_MEM_SEL;
            mem_addr_sel = 1'b1;
            exc_sel      = sel_q;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign cause = cause_q;
   assign lost  = lost_q;

endmodule

// File: tb/tb_exception_seq.sv
// Randomized scoreboard bench for exception_seq,
// three instances at MEM_LATENCY 2, 1 and 15.
module tb_exception_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic inv = 1'b0;
   logic ovf = 1'b0;
   logic dz = 1'b0;
   logic clr = 1'b0;

   int ecnt = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         e;
      logic [1:0] cause;
      logic [2:0] sel;
   } exp_t;

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

      logic       busy, done, mas, mr, epcw, pcw, lost;
      logic [2:0] exc_sel, pc_src;
      logic [1:0] cause;

      exception_seq #(.MEM_LATENCY(L), .PC_MEM_SEL(3'b011)) dut (
         .clk          (clk),
         .reset        (rst_n),
         .invalid_op   (inv),
         .overflow     (ovf),
         .div_zero     (dz),
         .lost_clr     (clr),
         .busy         (busy),
         .done         (done),
         .exc_sel      (exc_sel),
         .mem_addr_sel (mas),
         .mem_read     (mr),
         .epc_write    (epcw),
         .pc_write     (pcw),
         .pc_src_sel   (pc_src),
         .cause        (cause),
         .lost         (lost)
      );

      exp_t       q[$];
      int         ready_e = 0;
      int         last_e = 0;
      bit         has_last = 1'b0;
      logic       lost_m = 1'b0;
      logic [1:0] cause_m = 2'b00;
      logic [2:0] sel_m = 3'b000;

      // reference: an accepted request occupies edges e..e+3+L
      always @(posedge clk or negedge rst_n) begin
         logic       any;
         logic [1:0] c;
         logic [2:0] s;
         if (!rst_n) begin
            q.delete();
            ready_e  <= 0;
            has_last <= 1'b0;
            lost_m   <= 1'b0;
            cause_m  <= 2'b00;
            sel_m    <= 3'b000;
         end else begin
            any = inv | ovf | dz;
            c = inv ? 2'd1 : (ovf ? 2'd2 : 2'd3);
            s = inv ? 3'd0 : (ovf ? 3'd1 : 3'd2);
            if (any && ecnt >= ready_e) begin
               q.push_back('{ecnt, c, s});
               cause_m  <= c;
               sel_m    <= s;
               last_e   <= ecnt;
               has_last <= 1'b1;
               ready_e  <= ecnt + 4 + L;
            end
            if (any && ecnt < ready_e) lost_m <= 1'b1;
            else if (clr) lost_m <= 1'b0;
         end
      end

      int         m_epc = 0;
      int         m_nmr = 0;
      int         m_pcw = 0;
      logic [2:0] m_sel = 3'b000;
      logic [2:0] m_pcs = 3'b000;

      always @(negedge clk) begin
         int          d;
         logic [14:0] av;
         logic [14:0] ev;
         exp_t        x;
         av = {busy, done, mas, mr, epcw, pcw, exc_sel, pc_src, cause, lost};
         if (!rst_n) begin
            chk($sformatf("L%0d_reset_outputs", L), 32'(av), 32'd0);
            m_nmr = 0;
         end else begin
            d = has_last ? (ecnt - last_e) : -100;
            ev = {(d >= 1 && d <= 3 + L), (d == 3 + L),
                  (d >= 1 && d <= 2 + L), (d >= 2 && d <= 1 + L),
                  (d == 1), (d == 2 + L),
                  ((d >= 1 && d <= 2 + L) ? sel_m : 3'd0),
                  ((d == 2 + L) ? 3'b011 : 3'b000),
                  cause_m, lost_m};
            chk($sformatf("L%0d_outputs", L), 32'(av), 32'(ev));
            if (epcw) begin
               m_epc = ecnt;
               m_sel = exc_sel;
               m_nmr = 0;
            end
            if (mr) m_nmr++;
            if (pcw) begin
               m_pcw = ecnt;
               m_pcs = pc_src;
            end
            if (done) begin
               if (q.size() == 0) begin
                  chk($sformatf("L%0d_unexpected_done", L), 32'd1, 32'd0);
               end else begin
                  x = q.pop_front();
                  chk($sformatf("L%0d_epc_cycle", L), 32'(m_epc - x.e), 32'd1);
                  chk($sformatf("L%0d_memrd_cycles", L), 32'(m_nmr), 32'(L));
                  chk($sformatf("L%0d_pcw_cycle", L), 32'(m_pcw - x.e),
                      32'(2 + L));
                  chk($sformatf("L%0d_done_cycle", L), 32'(ecnt - x.e),
                      32'(3 + L));
                  chk($sformatf("L%0d_exc_sel", L), 32'(m_sel), 32'(x.sel));
                  chk($sformatf("L%0d_pc_src", L), 32'(m_pcs), 32'd3);
                  chk($sformatf("L%0d_cause", L), 32'(cause), 32'(x.cause));
               end
            end else if (q.size() != 0 && ecnt > q[0].e + 3 + L) begin
               chk($sformatf("L%0d_done_timeout", L), 32'd0, 32'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic cyc(input logic i, input logic o, input logic d,
                      input logic c);
      @(negedge clk);
      #1;
      inv = i;
      ovf = o;
      dz  = d;
      clr = c;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      inv = 1'b0;
      ovf = 1'b0;
      dz  = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      // lone overflow
      cyc(0, 1, 0, 0);
      idle(25);
      // simultaneous invalid_op and div_zero
      cyc(1, 0, 1, 0);
      idle(25);
      // div_zero while busy, then clear
      cyc(0, 1, 0, 0);
      idle(2);
      cyc(0, 0, 1, 0);
      idle(25);
      cyc(0, 0, 0, 1);
      idle(3);
      // reset mid-sequence, then a clean run
      cyc(0, 1, 0, 0);
      idle(2);
      pulse_reset();
      cyc(0, 1, 0, 0);
      idle(25);
      // DONE-cycle pulse for L=2, then an IDLE pulse
      cyc(0, 1, 0, 0);
      idle(4);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      idle(25);
      cyc(0, 0, 0, 1);
      // random traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 249) == 0) begin
            pulse_reset();
         end else begin
            cyc(1'($urandom_range(0, 99) < 5),
                1'($urandom_range(0, 99) < 5),
                1'($urandom_range(0, 99) < 5),
                1'($urandom_range(0, 99) < 10));
         end
      end
      idle(25);
      chk("L2_queue_drained", 32'(u[0].q.size()), 32'd0);
      chk("L1_queue_drained", 32'(u[1].q.size()), 32'd0);
      chk("L15_queue_drained", 32'(u[2].q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
